// File: rtl/mac_load_seq_pkg.sv
// Shared types and constants for the matrix MAC operand load sequencer.
package mac_load_seq_pkg;

    // Sequencer states: idle, A-row reads, B-row reads, last-word drain, done pulse.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mac_ld_state_t;

    localparam int MAC_ROWS   = 3;
    localparam int WORD_BYTES = 4;
    localparam int SLOT_W     = 3;

    // Row-register slot for a read: A rows occupy 0..rows-1, B rows follow them.
    function automatic logic [SLOT_W-1:0] slot_of(input logic is_b,
                                                   input logic [1:0] cnt,
                                                   input int rows);
        logic [SLOT_W-1:0] base_s;
        base_s = is_b ? SLOT_W'(rows) : {SLOT_W{1'b0}};
        return base_s + SLOT_W'(cnt);
    endfunction

endpackage

// File: rtl/mac_ld_capture.sv
// Capture stage: delays the issued slot by one cycle and steers returning
// read data into the six MAC operand registers.
module mac_ld_capture
    import mac_load_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [SLOT_W-1:0] issue_slot,
    input  logic [WIDTH-1:0]  rdata,
    output logic [WIDTH-1:0]  a_row1,
    output logic [WIDTH-1:0]  a_row2,
    output logic [WIDTH-1:0]  a_row3,
    output logic [WIDTH-1:0]  b_row1,
    output logic [WIDTH-1:0]  b_row2,
    output logic [WIDTH-1:0]  b_row3
);

    logic [SLOT_W-1:0] slot_r;
    logic              valid_r;
    logic [WIDTH-1:0]  a_row1_r, a_row2_r, a_row3_r;
    logic [WIDTH-1:0]  b_row1_r, b_row2_r, b_row3_r;

    // Track last cycle's issue and write the returning word into its row register.
    // A flush drops the read issued in that cycle; data already in flight still lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_r   <= {SLOT_W{1'b0}};
            valid_r  <= 1'b0;
            a_row1_r <= {WIDTH{1'b0}};
            a_row2_r <= {WIDTH{1'b0}};
            a_row3_r <= {WIDTH{1'b0}};
            b_row1_r <= {WIDTH{1'b0}};
            b_row2_r <= {WIDTH{1'b0}};
            b_row3_r <= {WIDTH{1'b0}};
        end else begin
            valid_r <= issue_valid & ~flush;
            slot_r  <= issue_slot;
            if (valid_r) begin
                case (slot_r)
                    3'd0:    a_row1_r <= rdata;
                    3'd1:    a_row2_r <= rdata;
                    3'd2:    a_row3_r <= rdata;
                    3'd3:    b_row1_r <= rdata;
                    3'd4:    b_row2_r <= rdata;
                    3'd5:    b_row3_r <= rdata;
                    default: a_row1_r <= a_row1_r;
                endcase
            end else begin
                a_row1_r <= a_row1_r;
            end
        end
    end

    assign a_row1 = a_row1_r;
    assign a_row2 = a_row2_r;
    assign a_row3 = a_row3_r;
    assign b_row1 = b_row1_r;
    assign b_row2 = b_row2_r;
    assign b_row3 = b_row3_r;

endmodule

// File: rtl/mac_load_seq.sv
// Read-side sequencer for the matrix MAC path: fetches three A rows and three
// B rows as six word reads and holds them as mac_wrapper operands.
module mac_load_seq
    import mac_load_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ROWS  = MAC_ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base_a,
    input  logic [WIDTH-1:0] base_b,
    input  logic             flush,
    output logic             mem_rd_en,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             align_err,
    output logic [WIDTH-1:0] a_row1,
    output logic [WIDTH-1:0] a_row2,
    output logic [WIDTH-1:0] a_row3,
    output logic [WIDTH-1:0] b_row1,
    output logic [WIDTH-1:0] b_row2,
    output logic [WIDTH-1:0] b_row3
);

    localparam logic [1:0] CNT_LAST = 2'(ROWS - 1);

    mac_ld_state_t     state_r;
    logic [1:0]        cnt_r;
    logic [WIDTH-1:0]  base_a_r;
    logic [WIDTH-1:0]  base_b_r;
    logic              align_err_r;
    logic              busy_r;
    logic              done_r;

    logic              rd_en_s;
    logic [WIDTH-1:0]  addr_s;
    logic [WIDTH-1:0]  offset_s;
    logic [SLOT_W-1:0] issue_slot_s;

    // Read strobe and word address decoded from state, counter and latched bases.
    always_comb begin
        rd_en_s      = 1'b0;
        addr_s       = {WIDTH{1'b0}};
        offset_s     = WIDTH'(cnt_r) * WIDTH'(WORD_BYTES);
        issue_slot_s = slot_of(state_r == ST_RD_B, cnt_r, ROWS);
        case (state_r)
            ST_RD_A: begin
                rd_en_s = 1'b1;
                addr_s  = base_a_r + offset_s;
            end
            ST_RD_B: begin
                rd_en_s = 1'b1;
                addr_s  = base_b_r + offset_s;
            end
            default: begin
                rd_en_s = 1'b0;
                addr_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // Burst FSM; busy/done are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            base_a_r    <= {WIDTH{1'b0}};
            base_b_r    <= {WIDTH{1'b0}};
            align_err_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        base_a_r    <= {base_a[WIDTH-1:2], 2'b00};
                        base_b_r    <= {base_b[WIDTH-1:2], 2'b00};
                        align_err_r <= (|base_a[1:0]) | (|base_b[1:0]);
                        cnt_r       <= 2'd0;
                        state_r     <= ST_RD_A;
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RD_A: begin
                    busy_r <= 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= 2'd0;
                        state_r <= ST_RD_B;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                ST_RD_B: begin
                    busy_r <= 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= 2'd0;
                        state_r <= ST_DRAIN;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    // Last word lands at the end of this cycle; stall drops with done.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 2'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    mac_ld_capture #(
        .WIDTH (WIDTH)
    ) u_capture (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_valid (rd_en_s),
        .issue_slot  (issue_slot_s),
        .rdata       (mem_rdata),
        .a_row1      (a_row1),
        .a_row2      (a_row2),
        .a_row3      (a_row3),
        .b_row1      (b_row1),
        .b_row2      (b_row2),
        .b_row3      (b_row3)
    );

    assign mem_rd_en = rd_en_s;
    assign mem_addr  = addr_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign align_err = align_err_r;

endmodule
